// File: rtl/regfile_sb.sv
// Integer register file with two registered read ports, one write port and a
// busy-bit scoreboard that raises a combinational RAW stall on pending producers.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] out1,
  output logic [XLEN-1:0] out2,
  input  logic            rw,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] dataIn,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            clr,
  output logic            stall,
  output logic [AW:0]     busy_cnt
);

  localparam int unsigned NREGS = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [XLEN-1:0]  val1;
  logic [XLEN-1:0]  val2;
  logic             hz1;
  logic             hz2;
  logic             eff_iss;
  logic             wr_en;
  logic             inc;
  logic             dec;

  // Read value selection: hardwired zero, then same-cycle forwarding, then array
  always_comb begin
    val1 = mem[rs1];
    val2 = mem[rs2];
    if (BYPASS && rw && (rd == rs1)) val1 = dataIn;
    if (BYPASS && rw && (rd == rs2)) val2 = dataIn;
    if (ZERO_REG && (rs1 == '0)) val1 = '0;
    if (ZERO_REG && (rs2 == '0)) val2 = '0;
  end

  // Hazard: source still pending unless its producer writes back this cycle
  always_comb begin
    hz1   = busy[rs1] & ~(BYPASS & rw & (rd == rs1));
    hz2   = busy[rs2] & ~(BYPASS & rw & (rd == rs2));
    stall = rd_en & (hz1 | hz2);
  end

  // Scoreboard next state; issue overrides a writeback to the same register
  always_comb begin
    wr_en    = rw & ~(ZERO_REG & (rd == '0));
    eff_iss  = iss_en & ~stall & ~(ZERO_REG & (iss_rd == '0));
    inc      = eff_iss & ~busy[iss_rd];
    dec      = rw & busy[rd] & ~(eff_iss & (iss_rd == rd));
    busy_nxt = busy;
    cnt_nxt  = busy_cnt + CW'(inc) - CW'(dec);
    if (rw) busy_nxt[rd] = 1'b0;
    if (eff_iss) busy_nxt[iss_rd] = 1'b1;
    if (clr) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
      out1     <= '0;
      out2     <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_en) mem[rd] <= dataIn;
      if (rd_en && !stall) begin
        out1 <= val1;
        out2 <= val2;
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule
